mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Upstream sequencer for single_port_memory: turns a burst command (write or read, start address, length) into a cycle-by-cycle drive of the memory's mode/addr/data_in.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream with a one-entry output register.
- Guarantees the memory never sees a write cycle it was not asked for.

Parameters:
- ADDR_W, 5, memory address width; depth = 2**ADDR_W = 32.
- DATA_W, 32, memory word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_W  start address.
- cmd_len  input  ADDR_W+1  beat count, 0..32.
- wr_valid  input  1  write beat offered.
- wr_ready  output  1  write beat accepted.
- wr_data  input  DATA_W  write beat data.
- rd_valid  output  1  read beat held.
- rd_ready  input  1  read beat consumed.
- rd_data  output  DATA_W  read beat data.
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  one-cycle pulse, burst complete.
- mem_mode  output  1  to memory: 0 = write (scribble), 1 = read (interpret).
- mem_addr  output  ADDR_W  to memory address.
- mem_data_in  output  DATA_W  to memory write data.
- mem_data_out  input  DATA_W  from memory. Treated as combinational read of mem[mem_addr] when mem_mode = 1.

Behaviour:
- **States:** IDLE, WRITE, READ. Internal registers are cur_addr (ADDR_W) and remaining (ADDR_W+1).
- **Reset** (async, immediate):
  - State goes to IDLE; cur_addr, remaining, rd_data and done go to 0; rd_valid goes to 0.
  - Therefore mem_mode = 1, busy = 0, cmd_ready = 1 and wr_ready = 0 while rst is high.
  - Reset mid-burst abandons the burst with no done pulse. Memory words already written stay written.
- **Combinational outputs:**
  - cmd_ready = (state == IDLE).
  - wr_ready = (state == WRITE).
  - mem_addr = cur_addr.
  - mem_data_in = wr_data.
  - mem_mode = 0 only when state == WRITE && wr_valid; 1 in every other cycle. This is mandatory because the memory writes on every clock in mode 0.
- **IDLE:**
  - On command handshake: cur_addr <= cmd_addr, remaining <= cmd_len.
  - cmd_len == 0: stay IDLE and pulse done next cycle.
  - Otherwise go to WRITE if cmd_write, else READ.
- **WRITE:**
  - Each posedge with wr_valid: the memory stores wr_data at cur_addr; cur_addr <= cur_addr + 1 (wraps 31 -> 0); remaining decrements.
  - wr_valid low: no write, no advance; wait indefinitely.
  - Beat at remaining == 1: go to IDLE and assert done in the following cycle.
- **READ:**
  - Capture condition: (!rd_valid || rd_ready). When true at a posedge: rd_data <= mem_data_out, rd_valid <= 1, cur_addr advances (wraps), remaining decrements.
  - rd_ready held high gives one beat per cycle; first beat appears 1 cycle after entering READ.
  - rd_ready low with rd_valid high: hold rd_data and cur_addr (backpressure).
  - Capture at remaining == 1: go to IDLE and pulse done.
  - rd_valid clears when consumed and no new capture happens in that cycle.
- **Output register is independent of state:** rd_valid/rd_data of the last beat may remain pending in IDLE. A new command may be accepted meanwhile; a new read's first capture waits for the capture condition.
- **done:** registered; high exactly 1 cycle, in the cycle after the final beat (or after accepting a zero-length command).
- **Wrap:** a burst with addr + len > 32 wraps modulo 32. len = 32 touches every word exactly once.

Test Plan:
- Reset, then write burst addr=0 len=2, data 01234567, 89ABCDEF with wr_valid steady -> mem[0] = 01234567, mem[1] = 89ABCDEF; done 1 cycle after the 2nd beat; mem_mode = 1 in all other cycles.
- Read burst addr=0 len=2, rd_ready=1 -> rd_data 01234567 then 89ABCDEF on consecutive cycles; done pulses once.
- Wrap: write addr=31 len=2 (AAAA0001, AAAA0002), then read addr=31 len=2 -> mem[31] = AAAA0001, mem[0] = AAAA0002; readback in that order.
- Backpressure and gaps:
  - Read len=3 with rd_ready low for 4 cycles after the first beat -> rd_data holds, mem_addr frozen, no beats lost or duplicated.
  - Write with wr_valid gaps -> mem_mode stays 1 during the gaps and no extra writes occur.
- cmd_len=0 -> no memory write, done pulses 1 cycle later, busy stays 0.
- Assert rst mid-write (after beat 1 of 4) -> state IDLE immediately, mem_mode = 1, rd_valid = 0, no done; words 2..4 unchanged.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for single_port_memory: converts a write/read burst command into per-cycle
// mode/addr/data drive, with a valid/ready write stream and a one-entry registered read stream.
module mem_burst_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                done_q, done_d;
    logic                last_beat;
    logic                capture;

    assign last_beat = (remaining_q == (ADDR_W + 1)'(1));
    // Output register may take a new word when empty or being drained this cycle.
    assign capture   = !rd_valid_q || rd_ready;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q && !rd_ready;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                if (wr_valid) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StRead: begin
                if (capture) begin
                    rd_data_d   = mem_data_out;
                    rd_valid_d  = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign wr_ready    = (state_q == StWrite);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_addr    = cur_addr_q;
    assign mem_data_in = wr_data;
    // The memory writes on every clock in mode 0, so only a real write beat may select it.
    assign mem_mode    = !((state_q == StWrite) && wr_valid);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: a behavioural single-port memory, a burst-level
// reference model compared every cycle, directed literal checks and a randomized phase.
module tb_mem_burst_ctrl;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        busy, done, mem_mode;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data_in, mem_data_out;

    mem_burst_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical memory seen by the DUT.
    logic [31:0] mem [32];
    always @(posedge clk) if (!mem_mode) mem[mem_addr] <= mem_data_in;
    assign mem_data_out = mem[mem_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int wr_pct  = 100;
    int rd_pct  = 100;
    logic [31:0] wr_q[$];
    logic [31:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory plus burst progress in plain integers.
    logic [31:0] ref_mem [32];
    bit          m_busy, m_write, m_rv, m_done;
    int          m_addr, m_left;
    logic [31:0] m_rd;

    initial begin
        bit new_done, new_rv;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_mode", 64'(mem_mode), 64'(1));
                chk("rst_rd_valid", 64'(rd_valid), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
                chk("rst_wr_ready", 64'(wr_ready), 64'(0));
                m_busy = 0; m_write = 0; m_rv = 0; m_done = 0; m_addr = 0; m_left = 0;
            end else begin
                chk("busy", 64'(busy), 64'(m_busy));
                chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
                chk("wr_ready", 64'(wr_ready), 64'(m_busy && m_write));
                chk("mem_mode", 64'(mem_mode), 64'(!(m_busy && m_write && wr_valid)));
                chk("done", 64'(done), 64'(m_done));
                chk("rd_valid", 64'(rd_valid), 64'(m_rv));
                if (m_rv) chk("rd_data", 64'(rd_data), 64'(m_rd));
                if (m_busy) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                if (!mem_mode) chk("mem_data_in", 64'(mem_data_in), 64'(wr_data));
                if (done) n_done++;
                if (rd_valid && rd_ready) got.push_back(rd_data);

                new_done = 0;
                new_rv = m_rv && !rd_ready;
                if (!m_busy) begin
                    if (cmd_valid) begin
                        m_addr = int'(cmd_addr);
                        m_left = int'(cmd_len);
                        if (m_left == 0) new_done = 1;
                        else begin
                            m_busy = 1;
                            m_write = cmd_write;
                        end
                    end
                end else if (m_write) begin
                    if (wr_valid) begin
                        ref_mem[m_addr] = wr_data;
                        m_addr = (m_addr + 1) % 32;
                        m_left--;
                        if (m_left == 0) begin m_busy = 0; new_done = 1; end
                    end
                end else if (!m_rv || rd_ready) begin
                    m_rd = ref_mem[m_addr];
                    new_rv = 1;
                    m_addr = (m_addr + 1) % 32;
                    m_left--;
                    if (m_left == 0) begin m_busy = 0; new_done = 1; end
                end
                m_rv = new_rv;
                m_done = new_done;
            end
        end
    end

    // Stream driver: write beats come from wr_q with random gaps; rd_ready is random.
    initial begin
        bit do_pop;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            do_pop = wr_valid && wr_ready && !rst;
            @(posedge clk);
            #1;
            if (do_pop && wr_q.size() > 0) void'(wr_q.pop_front());
            wr_valid = (wr_q.size() > 0) && ($urandom_range(99) < wr_pct);
            wr_data  = (wr_q.size() > 0) ? wr_q[0] : $urandom;
            rd_ready = ($urandom_range(99) < rd_pct);
        end
    end

    task automatic issue(input bit w, input int addr, input int len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = 5'(addr);
        cmd_len   = 6'(len);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        chk("cmd_timeout", 64'(0), 64'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (n_done >= target) return;
        end
        chk("done_timeout", 64'(n_done), 64'(target));
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!rd_valid) return;
        end
        chk("drain_timeout", 64'(rd_valid), 64'(0));
    endtask

    task automatic burst(input bit w, input int addr, input int len);
        int base;
        base = n_done;
        issue(w, addr, len);
        wait_done(base + 1);
    endtask

    initial begin
        int d0, len;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'hDEAD0000 | 32'(i);
            ref_mem[i] = 32'hDEAD0000 | 32'(i);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic write then read.
        wr_pct = 100; rd_pct = 100;
        wr_q = '{32'h01234567, 32'h89ABCDEF};
        burst(1, 0, 2);
        chk("t1_mem0", 64'(mem[0]), 64'(32'h01234567));
        chk("t1_mem1", 64'(mem[1]), 64'(32'h89ABCDEF));
        chk("t1_done_count", 64'(n_done), 64'(1));
        got.delete();
        burst(0, 0, 2);
        drain();
        chk("t2_beats", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            chk("t2_beat0", 64'(got[0]), 64'(32'h01234567));
            chk("t2_beat1", 64'(got[1]), 64'(32'h89ABCDEF));
        end

        // Wrap around the top of memory.
        wr_q = '{32'hAAAA0001, 32'hAAAA0002};
        burst(1, 31, 2);
        chk("t3_mem31", 64'(mem[31]), 64'(32'hAAAA0001));
        chk("t3_mem0", 64'(mem[0]), 64'(32'hAAAA0002));
        got.delete();
        burst(0, 31, 2);
        drain();
        chk("t3_beats", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            chk("t3_beat0", 64'(got[0]), 64'(32'hAAAA0001));
            chk("t3_beat1", 64'(got[1]), 64'(32'hAAAA0002));
        end

        // Read backpressure: hold rd_ready low for 4 cycles after the first beat.
        got.delete();
        rd_pct = 0;
        d0 = n_done;
        issue(0, 5, 3);
        for (int i = 0; i < 50 && !rd_valid; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        rd_pct = 100;
        wait_done(d0 + 1);
        drain();
        chk("t4_beats", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            chk("t4_beat0", 64'(got[0]), 64'(32'hDEAD0005));
            chk("t4_beat1", 64'(got[1]), 64'(32'hDEAD0006));
            chk("t4_beat2", 64'(got[2]), 64'(32'hDEAD0007));
        end

        // Write with gaps in wr_valid.
        wr_pct = 40;
        wr_q = '{32'h11110008, 32'h22220009, 32'h3333000A, 32'h4444000B};
        burst(1, 8, 4);
        chk("t5_mem8", 64'(mem[8]), 64'(32'h11110008));
        chk("t5_mem11", 64'(mem[11]), 64'(32'h4444000B));
        chk("t5_mem12", 64'(mem[12]), 64'(32'hDEAD000C));

        // Zero-length command.
        d0 = n_done;
        issue(1, 20, 0);
        repeat (2) @(posedge clk);
        chk("t6_done_count", 64'(n_done), 64'(d0 + 1));
        chk("t6_mem20", 64'(mem[20]), 64'(32'hDEAD0014));

        // Reset after the first of four write beats.
        wr_pct = 100;
        wr_q = '{32'h5555000C, 32'h5555000D, 32'h5555000E, 32'h5555000F};
        d0 = n_done;
        issue(1, 12, 4);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_valid && wr_ready) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr_q.delete();
        #1;
        chk("t7_mode_now", 64'(mem_mode), 64'(1));
        chk("t7_busy_now", 64'(busy), 64'(0));
        chk("t7_rd_valid_now", 64'(rd_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("t7_mem12", 64'(mem[12]), 64'(32'h5555000C));
        chk("t7_mem13", 64'(mem[13]), 64'(32'hDEAD000D));
        chk("t7_mem14", 64'(mem[14]), 64'(32'hDEAD000E));
        chk("t7_mem15", 64'(mem[15]), 64'(32'hDEAD000F));
        chk("t7_no_done", 64'(n_done), 64'(d0));

        // Randomized bursts with random stream throttling.
        for (int n = 0; n < 60; n++) begin
            wr_pct = $urandom_range(30, 100);
            rd_pct = $urandom_range(30, 100);
            case ($urandom_range(9))
                0:       len = 0;
                1:       len = 32;
                default: len = $urandom_range(1, 31);
            endcase
            if ($urandom_range(1)) begin
                for (int k = 0; k < len; k++) wr_q.push_back($urandom);
                burst(1, $urandom_range(31), len);
            end else begin
                burst(0, $urandom_range(31), len);
            end
        end
        rd_pct = 100;
        drain();
        for (int i = 0; i < 32; i++) chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
